// File: rtl/calc_entry_if.sv
// Keypad-to-display bundle for the calculator entry core: key level/code in, display and status out.
interface calc_entry_if #(
    parameter int unsigned WIDTH = 10
);
    logic             key_pressed;
    logic [3:0]       keycode;
    logic [WIDTH-1:0] display_value;
    logic             overflow;
    logic             busy;
    logic [1:0]       op_pending;
    logic [2:0]       state_code;
    logic [7:0]       keypress_count;

    modport master (
        output key_pressed, keycode,
        input  display_value, overflow, busy, op_pending, state_code, keypress_count
    );

    modport slave (
        input  key_pressed, keycode,
        output display_value, overflow, busy, op_pending, state_code, keypress_count
    );
endinterface

// File: rtl/calc_entry_core.sv
// Digit-entry and arithmetic engine: edge-detects keypad presses, builds decimal operands,
// and evaluates add/sub/shift-add multiply with overflow trapping into an ERROR state.
module calc_entry_core #(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned MAX_DIGITS = 3,
    parameter int unsigned MAX_VALUE  = 999
) (
    input  logic         clk,
    input  logic         rst_n,
    calc_entry_if.slave  bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned DW = $clog2(MAX_DIGITS + 1);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] S_ENTRY_A = 3'd0;
    localparam logic [2:0] S_ENTRY_B = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_RESULT  = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_MUL  = 2'd3;

    localparam logic [3:0] K_EQ  = 4'hD;
    localparam logic [3:0] K_CE  = 4'hE;
    localparam logic [3:0] K_AC  = 4'hF;

    logic [2:0]       state_q, state_d;
    logic             prev_q;
    logic [WIDTH-1:0] entry_q, entry_d;
    logic [DW-1:0]    digits_q, digits_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       next_op_q, next_op_d;
    logic             chain_q, chain_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       count_q, count_d;
    logic [WIDTH-1:0] display_q, display_d;
    logic             overflow_q, busy_q;

    logic             key_ev_c;
    logic             is_digit_c, is_op_c;
    logic [1:0]       key_op_c;
    logic [WIDTH-1:0] digit_val_c;
    logic [WIDTH:0]   add_sum_c;
    logic [PW-1:0]    mul_sum_c;
    logic             exec_done_c, exec_err_c;
    logic [WIDTH-1:0] exec_res_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_ENTRY_A;
            prev_q     <= 1'b0;
            entry_q    <= '0;
            digits_q   <= '0;
            acc_q      <= '0;
            op_q       <= OP_NONE;
            next_op_q  <= OP_NONE;
            chain_q    <= 1'b0;
            prod_q     <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            count_q    <= '0;
            display_q  <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= bus.key_pressed;
            entry_q    <= entry_d;
            digits_q   <= digits_d;
            acc_q      <= acc_d;
            op_q       <= op_d;
            next_op_q  <= next_op_d;
            chain_q    <= chain_d;
            prod_q     <= prod_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            count_q    <= count_d;
            display_q  <= display_d;
            overflow_q <= (state_d == S_ERROR);
            busy_q     <= (state_d == S_EXEC);
        end
    end

    // Next-state, datapath and display logic
    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        digits_d    = digits_q;
        acc_d       = acc_q;
        op_d        = op_q;
        next_op_d   = next_op_q;
        chain_d     = chain_q;
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        count_d     = count_q;
        display_d   = display_q;
        exec_done_c = 1'b0;
        exec_err_c  = 1'b0;
        exec_res_c  = acc_q;

        key_ev_c    = bus.key_pressed & ~prev_q;
        is_digit_c  = (bus.keycode <= 4'd9);
        is_op_c     = (bus.keycode >= 4'hA) && (bus.keycode <= 4'hC);
        key_op_c    = 2'(bus.keycode - 4'd9);
        digit_val_c = WIDTH'(bus.keycode);
        add_sum_c   = {1'b0, acc_q} + {1'b0, entry_q};
        mul_sum_c   = prod_q + (mplier_q[0] ? mcand_q : '0);

        if (state_q == S_EXEC) begin
            case (op_q)
                OP_ADD: begin
                    exec_done_c = 1'b1;
                    exec_err_c  = (add_sum_c > (WIDTH+1)'(MAX_VALUE));
                    exec_res_c  = add_sum_c[WIDTH-1:0];
                end
                OP_SUB: begin
                    exec_done_c = 1'b1;
                    exec_err_c  = (entry_q > acc_q);
                    exec_res_c  = acc_q - entry_q;
                end
                OP_MUL: begin
                    // One multiplier bit per cycle; the full-width product is checked at the end
                    prod_d      = mul_sum_c;
                    mcand_d     = mcand_q << 1;
                    mplier_d    = mplier_q >> 1;
                    cnt_d       = cnt_q + CW'(1);
                    exec_done_c = (cnt_q == CW'(WIDTH - 1));
                    exec_err_c  = (mul_sum_c > PW'(MAX_VALUE));
                    exec_res_c  = mul_sum_c[WIDTH-1:0];
                end
                default: exec_done_c = 1'b1;
            endcase

            if (exec_done_c) begin
                entry_d  = '0;
                digits_d = '0;
                if (exec_err_c) begin
                    state_d = S_ERROR;
                    op_d    = OP_NONE;
                end else begin
                    acc_d = exec_res_c;
                    if (chain_q) begin
                        op_d    = next_op_q;
                        state_d = S_ENTRY_B;
                    end else begin
                        op_d    = OP_NONE;
                        state_d = S_RESULT;
                    end
                end
            end
        end else if (key_ev_c) begin
            count_d = count_q + 8'd1;
            if (bus.keycode == K_AC) begin
                state_d   = S_ENTRY_A;
                entry_d   = '0;
                digits_d  = '0;
                acc_d     = '0;
                op_d      = OP_NONE;
                next_op_d = OP_NONE;
                chain_d   = 1'b0;
            end else begin
                case (state_q)
                    S_ENTRY_A, S_ENTRY_B: begin
                        if (is_digit_c) begin
                            if (digits_q < DW'(MAX_DIGITS)) begin
                                entry_d  = (entry_q << 3) + (entry_q << 1) + digit_val_c;
                                digits_d = digits_q + DW'(1);
                            end
                        end else if (bus.keycode == K_CE) begin
                            entry_d  = '0;
                            digits_d = '0;
                        end else if (is_op_c) begin
                            if (state_q == S_ENTRY_A) begin
                                acc_d    = entry_q;
                                entry_d  = '0;
                                digits_d = '0;
                                op_d     = key_op_c;
                                state_d  = S_ENTRY_B;
                            end else if (digits_q == '0) begin
                                op_d = key_op_c;
                            end else begin
                                next_op_d = key_op_c;
                                chain_d   = 1'b1;
                                state_d   = S_EXEC;
                            end
                        end else if (bus.keycode == K_EQ && state_q == S_ENTRY_B && digits_q != '0) begin
                            chain_d = 1'b0;
                            state_d = S_EXEC;
                        end
                    end
                    S_RESULT: begin
                        if (is_digit_c) begin
                            entry_d  = digit_val_c;
                            digits_d = DW'(1);
                            acc_d    = '0;
                            op_d     = OP_NONE;
                            state_d  = S_ENTRY_A;
                        end else if (is_op_c) begin
                            entry_d  = '0;
                            digits_d = '0;
                            op_d     = key_op_c;
                            state_d  = S_ENTRY_B;
                        end
                    end
                    default: ;
                endcase
            end

            if (state_d == S_EXEC) begin
                prod_d   = '0;
                mcand_d  = PW'(acc_q);
                mplier_d = entry_q;
                cnt_d    = '0;
            end
        end

        // Display follows the post-edge state so it updates on the same edge as the key event
        case (state_d)
            S_ENTRY_A: display_d = entry_d;
            S_ENTRY_B: display_d = (digits_d == '0) ? acc_d : entry_d;
            S_RESULT:  display_d = acc_d;
            S_ERROR:   display_d = '0;
            default:   display_d = display_q;
        endcase
    end

    assign bus.display_value  = display_q;
    assign bus.overflow       = overflow_q;
    assign bus.busy           = busy_q;
    assign bus.op_pending     = op_q;
    assign bus.state_code     = state_q;
    assign bus.keypress_count = count_q;

endmodule

// File: tb/tb_calc_entry_core.sv
// Directed self-checking bench for calc_entry_core: entry, arithmetic, chaining, errors, reset.
module tb_calc_entry_core;
    localparam int unsigned WIDTH = 10;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errs;
    int   exp_cnt;
    int   n;

    calc_entry_if #(.WIDTH(WIDTH)) bus ();

    calc_entry_core #(.WIDTH(WIDTH), .MAX_DIGITS(3), .MAX_VALUE(999)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive a key at a falling edge; returns at the falling edge after the event edge
    task automatic key_down(input logic [3:0] k);
        @(negedge clk);
        bus.key_pressed = 1'b1;
        bus.keycode     = k;
        @(negedge clk);
    endtask

    task automatic key_up();
        bus.key_pressed = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        key_down(k);
        key_up();
        exp_cnt++;
    endtask

    // Release the key and count consecutive busy cycles, bounded
    task automatic count_busy(output int cycles);
        cycles = 0;
        bus.key_pressed = 1'b0;
        while (bus.busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        exp_cnt = 0;
        rst_n   = 1'b0;
        bus.key_pressed = 1'b0;
        bus.keycode     = 4'h0;
        repeat (3) @(negedge clk);

        check("rst_display", 32'(bus.display_value), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_op", 32'(bus.op_pending), 0);
        check("rst_state", 32'(bus.state_code), 0);
        check("rst_count", 32'(bus.keypress_count), 0);
        rst_n = 1'b1;

        // Three-digit limit
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("digits_display", 32'(bus.display_value), 123);
        check("digits_count", 32'(bus.keypress_count), 4);
        check("digits_state", 32'(bus.state_code), 0);

        // 12 + 34
        press(4'hF);
        press(4'd1); press(4'd2); press(4'hA);
        check("add_state_b", 32'(bus.state_code), 1);
        check("add_op", 32'(bus.op_pending), 1);
        check("add_show_acc", 32'(bus.display_value), 12);
        press(4'd3);
        check("add_first_digit", 32'(bus.display_value), 3);
        press(4'd4);
        key_down(4'hD); exp_cnt++;
        count_busy(n);
        check("add_busy_cycles", 32'(n), 1);
        check("add_result", 32'(bus.display_value), 46);
        check("add_state_result", 32'(bus.state_code), 3);
        check("add_op_cleared", 32'(bus.op_pending), 0);
        check("add_count", 32'(bus.keypress_count), 32'(exp_cnt));

        // 25 * 39 = 975, then * 2 overflows
        press(4'hF);
        press(4'd2); press(4'd5); press(4'hC); press(4'd3); press(4'd9);
        key_down(4'hD); exp_cnt++;
        count_busy(n);
        check("mul_busy_cycles", 32'(n), 10);
        check("mul_result", 32'(bus.display_value), 975);
        press(4'hC);
        check("mul_reuse_state", 32'(bus.state_code), 1);
        check("mul_reuse_display", 32'(bus.display_value), 975);
        press(4'd2);
        key_down(4'hD); exp_cnt++;
        count_busy(n);
        check("ovf_busy_cycles", 32'(n), 10);
        check("ovf_state", 32'(bus.state_code), 4);
        check("ovf_flag", 32'(bus.overflow), 1);
        check("ovf_display", 32'(bus.display_value), 0);
        press(4'd5);
        check("err_sticky", 32'(bus.state_code), 4);
        press(4'hF);
        check("ac_state", 32'(bus.state_code), 0);
        check("ac_overflow", 32'(bus.overflow), 0);
        check("ac_display", 32'(bus.display_value), 0);

        // 5 - 7 is negative
        press(4'd5); press(4'hB); press(4'd7);
        key_down(4'hD); exp_cnt++;
        count_busy(n);
        check("neg_state", 32'(bus.state_code), 4);
        check("neg_overflow", 32'(bus.overflow), 1);
        press(4'hF);

        // Chaining: 9 + 1 = 10, then - 3 = 7
        press(4'd9); press(4'hA); press(4'd1);
        key_down(4'hB); exp_cnt++;
        count_busy(n);
        check("chain_busy", 32'(n), 1);
        check("chain_mid_display", 32'(bus.display_value), 10);
        check("chain_mid_state", 32'(bus.state_code), 1);
        check("chain_mid_op", 32'(bus.op_pending), 2);
        press(4'd3);
        key_down(4'hD); exp_cnt++;
        count_busy(n);
        check("chain_result", 32'(bus.display_value), 7);
        check("chain_state", 32'(bus.state_code), 3);

        // Operator replacement, clear-entry, then 4 * 6
        press(4'hF);
        press(4'd4); press(4'hA); press(4'hC);
        check("op_replace", 32'(bus.op_pending), 3);
        check("op_replace_state", 32'(bus.state_code), 1);
        press(4'd5); press(4'hE);
        check("ce_show_acc", 32'(bus.display_value), 4);
        press(4'd6);
        key_down(4'hD); exp_cnt++;
        count_busy(n);
        check("ce_mul_result", 32'(bus.display_value), 24);
        press(4'd8);
        check("result_digit_state", 32'(bus.state_code), 0);
        check("result_digit_display", 32'(bus.display_value), 8);
        press(4'hD);
        check("eq_ignored_a", 32'(bus.state_code), 0);
        check("eq_ignored_count", 32'(bus.keypress_count), 32'(exp_cnt));

        // Key during multiply is dropped
        press(4'hF);
        press(4'd3); press(4'hC); press(4'd3);
        key_down(4'hD); exp_cnt++;
        key_up();
        key_down(4'd5);
        key_up();
        count_busy(n);
        check("drop_result", 32'(bus.display_value), 9);
        check("drop_count", 32'(bus.keypress_count), 32'(exp_cnt));

        // Held key gives a single event
        press(4'hF);
        @(negedge clk);
        bus.key_pressed = 1'b1;
        bus.keycode     = 4'd7;
        repeat (1000) @(negedge clk);
        bus.key_pressed = 1'b0;
        exp_cnt++;
        @(negedge clk);
        check("hold_display", 32'(bus.display_value), 7);
        check("hold_count", 32'(bus.keypress_count), 32'(exp_cnt));

        // Asynchronous reset in the middle of a multiply
        press(4'hC); press(4'd9);
        key_down(4'hD);
        key_up();
        @(negedge clk);
        check("pre_reset_busy", 32'(bus.busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_display", 32'(bus.display_value), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_state", 32'(bus.state_code), 0);
        check("arst_count", 32'(bus.keypress_count), 0);
        check("arst_op", 32'(bus.op_pending), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_display", 32'(bus.display_value), 0);
        check("post_rst_busy", 32'(bus.busy), 0);
        check("post_rst_state", 32'(bus.state_code), 0);

        // Counter wrap at 255 -> 0 using keys with no effect
        for (int i = 0; i < 255; i++) press(4'hE);
        check("cnt_255", 32'(bus.keypress_count), 255);
        press(4'hE);
        check("cnt_wrap", 32'(bus.keypress_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/calc_entry_core.md
# calc_entry_core

Parametrised digit-entry and arithmetic engine for the keypad calculator. It consumes the level `key_pressed` and 4-bit keycode from the keypad poller/encoder pair, edge-detects key presses, and accumulates decimal operands. It evaluates add, subtract and multiply (sequential shift-add) and drives a binary `display_value` into the downstream bin-to-BCD converter and seven-segment driver. It replaces the ad-hoc keypress counter and "TODO number register" in the top level.

## Interface
- `WIDTH`, 10, operand/result width in bits; must hold `MAX_VALUE`.
- `MAX_DIGITS`, 3, maximum decimal digits per operand.
- `MAX_VALUE`, 999, largest legal result; anything above is overflow.
- `Clk` in 1: single clock, 12 MHz board clock.
- `reset` in 1: asynchronous, active-low; all state is cleared while low.
- `key_pressed` in 1: level from the poller; high while any key is held.
- `keycode` in 4: encoder output; valid whenever `key_pressed` is high.
- `display_value` out WIDTH: value to display.
- `overflow` out 1: high in ERROR.
- `busy` out 1: high while in EXEC.
- `op_pending` out 2: latched operator; 0 = none, 1 = add, 2 = sub, 3 = mul.
- `state_code` out 3: 0 = ENTRY_A, 1 = ENTRY_B, 2 = EXEC, 3 = RESULT, 4 = ERROR.
- `keypress_count` out 8: accepted key events, wraps 255 -> 0.

## Operation
- Key event: `key_pressed` high on the current edge and low on the previous edge (registered `prev`). `keycode` is sampled on that same edge. A held key produces exactly one event.
- Keycode map: 0–9 are digits; A is add; B is sub; C is mul; D is equals; E is clear-entry; F is all-clear.
- Digit: `entry <= entry*10 + d` and `digits++`. Ignored when `digits == MAX_DIGITS`.
- ENTRY_A:
  - Digits build `entry`; `display_value` shows `entry`.
  - An operator sets `acc <= entry` and `op_pending <= op`, clears `entry` and `digits`, and moves to ENTRY_B.
  - D is ignored.
- ENTRY_B:
  - Display shows `acc` until the first digit, then shows `entry`.
  - An operator with `digits == 0` replaces `op_pending`; the state is unchanged.
  - An operator with `digits > 0` goes to EXEC. The new operator becomes `op_pending` after EXEC completes, and the block returns to ENTRY_B (chaining).
  - D with `digits > 0` goes to EXEC, then RESULT, and `op_pending` is cleared. D with `digits == 0` is ignored.
- EXEC:
  - Add and sub complete in 1 cycle.
  - Mul runs a shift-add over the WIDTH bits of `entry` into a 2*WIDTH product, one bit per cycle.
  - Any result above `MAX_VALUE`, or a sub with `entry > acc`, sends the block to ERROR.
  - Otherwise `acc <= result`.
  - All key events during EXEC are dropped and not counted.
- RESULT:
  - Display shows `acc`.
  - A digit starts a new ENTRY_A with `entry = d`.
  - An operator uses `acc` as the first operand and moves to ENTRY_B.
- ERROR: `overflow = 1` and `display_value = 0`. Only F or reset exits, to ENTRY_A.
- E clears `entry` and `digits` in ENTRY_A or ENTRY_B; otherwise it is ignored.
- F in any state except EXEC clears everything except `keypress_count` and goes to ENTRY_A.
- `keypress_count` increments on every accepted event, including ignored digits and keys with no effect. It excludes events dropped during EXEC.

## Timing
- Reset values: `display_value = 0`, `overflow = 0`, `busy = 0`, `op_pending = 0`, `state_code = 0`, `keypress_count = 0`, internal `prev = 0`.
- Key event on edge N: state, entry and count are updated at edge N and visible after it. There is no further latency.
- `busy` is high exactly for the EXEC cycles:
  - 1 cycle for add/sub, so the result is visible 2 edges after the D event.
  - WIDTH cycles for mul, so the result is visible WIDTH+1 edges after the event.
- Overflow check uses the full 2*WIDTH product and a WIDTH+1-bit add, so there is no silent wrap.
- Reset asserted mid-EXEC aborts immediately; all outputs return to reset values asynchronously.
- `key_pressed` already high when reset deasserts: `prev` is 0, so an event fires on the first edge (accepted behaviour).

## Test plan
- Keys 1, 2, 3, 4 pressed once each, released between -> display 123, `keypress_count` = 4, 4th digit ignored.
- 1, 2, A, 3, 4, D -> display 46, state RESULT; `busy` high exactly 1 cycle.
- 2, 5, C, 3, 9, D -> display 975 after `busy` high for 10 cycles; then C, 2, D -> ERROR, `overflow` = 1, display 0; F -> ENTRY_A, display 0.
- 5, B, 7, D -> ERROR (negative result); 9, A, 1, B, 3, D -> chaining gives 10 then 7.
- Key 7 held 1000 cycles -> one event only; reset pulsed low mid-mul -> all outputs 0 within the same cycle, no stale result after release.
